// File: rtl/packet_reorder_emitter.sv
// In-order release of circular-buffer packets: waits on the per-slot status,
// drops or fetches the slot word, and emits passing packets over valid/ready.
module packet_reorder_emitter #(
    parameter int TAG_WIDTH            = 6,
    parameter int CIRCULAR_BUFFER_SIZE = 50,
    parameter int DATA_WIDTH           = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_valid,
    output logic                  alloc_stall,
    output logic [TAG_WIDTH-1:0]  cb_reorder_tag,
    input  logic [1:0]            cb_rd_packet_status,
    output logic                  clr_valid,
    output logic [TAG_WIDTH-1:0]  clr_tag,
    output logic                  mem_rd_en,
    output logic [TAG_WIDTH-1:0]  mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic [15:0]           emit_cnt,
    output logic [15:0]           drop_cnt,
    output logic                  overflow_err
);

    localparam int OCC_W = $clog2(CIRCULAR_BUFFER_SIZE + 1);

    typedef enum logic [1:0] {WAIT, FETCH, SEND} state_t;

    state_t                state;
    logic [OCC_W-1:0]      occ;
    logic [TAG_WIDTH-1:0]  tag;
    logic [TAG_WIDTH-1:0]  tag_next;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  send_first;
    logic                  alloc_ok;
    logic                  do_fetch;
    logic                  do_drop;
    logic                  handshake;
    logic                  release_pkt;

    assign alloc_stall    = (occ == OCC_W'(CIRCULAR_BUFFER_SIZE));
    assign cb_reorder_tag = tag;
    assign out_tag        = tag;
    // Read data lands in the first SEND cycle; it is forwarded then and held from data_q after.
    assign out_data       = send_first ? mem_rd_data : data_q;

    always_comb begin
        alloc_ok    = alloc_valid && !alloc_stall;
        do_fetch    = (state == WAIT) && (occ != '0) && cb_rd_packet_status[0] && cb_rd_packet_status[1];
        do_drop     = (state == WAIT) && (occ != '0) && cb_rd_packet_status[0] && !cb_rd_packet_status[1];
        handshake   = (state == SEND) && out_valid && out_ready;
        release_pkt = do_drop || handshake;
        tag_next    = (tag == TAG_WIDTH'(CIRCULAR_BUFFER_SIZE - 1)) ? '0 : tag + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ          <= '0;
            overflow_err <= 1'b0;
        end else begin
            case ({alloc_ok, release_pkt})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
            if (alloc_valid && alloc_stall)
                overflow_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= WAIT;
            tag         <= '0;
            clr_valid   <= 1'b0;
            clr_tag     <= '0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            out_valid   <= 1'b0;
            data_q      <= '0;
            send_first  <= 1'b0;
            emit_cnt    <= '0;
            drop_cnt    <= '0;
        end else begin
            clr_valid <= 1'b0;
            case (state)
                WAIT: begin
                    if (do_fetch) begin
                        state       <= FETCH;
                        mem_rd_en   <= 1'b1;
                        mem_rd_addr <= tag;
                    end else if (do_drop) begin
                        clr_valid <= 1'b1;
                        clr_tag   <= tag;
                        tag       <= tag_next;
                        drop_cnt  <= drop_cnt + 16'd1;
                    end
                end
                FETCH: begin
                    mem_rd_en  <= 1'b0;
                    out_valid  <= 1'b1;
                    send_first <= 1'b1;
                    state      <= SEND;
                end
                SEND: begin
                    send_first <= 1'b0;
                    if (send_first)
                        data_q <= mem_rd_data;
                    if (handshake) begin
                        out_valid <= 1'b0;
                        clr_valid <= 1'b1;
                        clr_tag   <= tag;
                        tag       <= tag_next;
                        emit_cnt  <= emit_cnt + 16'd1;
                        state     <= WAIT;
                    end
                end
                default: state <= WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_packet_reorder_emitter.sv
// Scoreboard bench for packet_reorder_emitter: models the status table and
// slot storage, queues expected emissions/clears, and checks them as they occur.
module tb_packet_reorder_emitter;

    localparam int TW = 6;
    localparam int N  = 50;
    localparam int DW = 64;

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          alloc_valid;
    logic          alloc_stall;
    logic [TW-1:0] cb_reorder_tag;
    logic [1:0]    cb_rd_packet_status;
    logic          clr_valid;
    logic [TW-1:0] clr_tag;
    logic          mem_rd_en;
    logic [TW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [TW-1:0] out_tag;
    logic [15:0]   emit_cnt;
    logic [15:0]   drop_cnt;
    logic          overflow_err;

    logic [DW-1:0] mem    [0:63];
    logic [1:0]    status [0:63];

    int      n_tests = 0;
    int      n_fail  = 0;
    bit      mon_en  = 1'b0;
    int      wr_ptr  = 0;
    exp_t    exp_out [$];
    logic [TW-1:0] exp_clr [$];

    always #5 clk = ~clk;

    assign cb_rd_packet_status = status[cb_reorder_tag];

    always @(posedge clk)
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

    packet_reorder_emitter #(
        .TAG_WIDTH(TW),
        .CIRCULAR_BUFFER_SIZE(N),
        .DATA_WIDTH(DW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .alloc_valid(alloc_valid),
        .alloc_stall(alloc_stall),
        .cb_reorder_tag(cb_reorder_tag),
        .cb_rd_packet_status(cb_rd_packet_status),
        .clr_valid(clr_valid),
        .clr_tag(clr_tag),
        .mem_rd_en(mem_rd_en),
        .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_tag(out_tag),
        .emit_cnt(emit_cnt),
        .drop_cnt(drop_cnt),
        .overflow_err(overflow_err)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Consecutive allocations; each writes fresh data into the next slot and clears its status.
    task automatic alloc_burst(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            tick();
            alloc_valid    = 1'b1;
            mem[wr_ptr]    = {$urandom, $urandom};
            status[wr_ptr] = 2'b00;
            wr_ptr         = (wr_ptr == N - 1) ? 0 : wr_ptr + 1;
        end
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic set_status(input int slot, input logic [1:0] v);
        exp_t e;
        status[slot] = v;
        if (v == 2'b11) begin
            e.tag  = TW'(slot);
            e.data = mem[slot];
            exp_out.push_back(e);
        end
        if (v[0]) exp_clr.push_back(TW'(slot));
    endtask

    task automatic monitor();
        exp_t e;
        logic [TW-1:0] t;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (out_valid && out_ready) begin
                    if (exp_out.size() == 0) check("out_unexpected", 64'(out_valid), 64'd0);
                    else begin
                        e = exp_out.pop_front();
                        check("out_tag", 64'(out_tag), 64'(e.tag));
                        check("out_data", out_data, e.data);
                    end
                end
                if (clr_valid) begin
                    if (exp_clr.size() == 0) check("clr_unexpected", 64'(clr_valid), 64'd0);
                    else begin
                        t = exp_clr.pop_front();
                        check("clr_tag", 64'(clr_tag), 64'(t));
                    end
                end
            end
        end
    endtask

    task automatic wait_out(input int limit);
        for (int i = 0; i < limit && !out_valid; i++) @(negedge clk);
        check("out_valid_wait", 64'(out_valid), 64'd1);
    endtask

    task automatic wait_drain(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (exp_out.size() == 0 && exp_clr.size() == 0) break;
            @(negedge clk);
        end
        check("drain", 64'(exp_out.size() + exp_clr.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] held;
        rst         = 1'b0;
        alloc_valid = 1'b0;
        out_ready   = 1'b1;
        for (int i = 0; i < 64; i++) begin
            status[i] = 2'b00;
            mem[i]    = '0;
        end
        fork
            monitor();
        join_none

        repeat (2) @(negedge clk);
        check("rst_alloc_stall", 64'(alloc_stall), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_clr_valid", 64'(clr_valid), 64'd0);
        check("rst_mem_rd_en", 64'(mem_rd_en), 64'd0);
        check("rst_tag", 64'(cb_reorder_tag), 64'd0);
        check("rst_counts", {32'd0, emit_cnt, drop_cnt}, 64'd0);
        check("rst_overflow", 64'(overflow_err), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        tick();
        rst    = 1'b1;
        mon_en = 1'b1;

        // Single pass packet on tag 0: latency profile.
        alloc_burst(1);
        set_status(0, 2'b11);
        @(negedge clk);
        check("pass_n_rd_en", 64'(mem_rd_en), 64'd0);
        @(negedge clk);
        check("pass_n1_rd_en", 64'(mem_rd_en), 64'd1);
        check("pass_n1_rd_addr", 64'(mem_rd_addr), 64'd0);
        check("pass_n1_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("pass_n2_out_valid", 64'(out_valid), 64'd1);
        check("pass_n2_out_tag", 64'(out_tag), 64'd0);
        @(negedge clk);
        check("pass_n3_clr_valid", 64'(clr_valid), 64'd1);
        check("pass_n3_out_valid", 64'(out_valid), 64'd0);
        check("pass_emit_cnt", 64'(emit_cnt), 64'd1);
        check("pass_tag", 64'(cb_reorder_tag), 64'd1);

        // Drop on tag 1.
        alloc_burst(1);
        set_status(1, 2'b01);
        @(negedge clk);
        check("drop_n_clr", 64'(clr_valid), 64'd0);
        @(negedge clk);
        check("drop_n1_clr", 64'(clr_valid), 64'd1);
        check("drop_cnt", 64'(drop_cnt), 64'd1);
        check("drop_tag", 64'(cb_reorder_tag), 64'd2);
        check("drop_no_out", 64'({out_valid, mem_rd_en}), 64'd0);

        // Backpressure on tag 2: outputs hold while out_ready is low.
        alloc_burst(1);
        out_ready = 1'b0;
        set_status(2, 2'b11);
        held = mem[2];
        wait_out(10);
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_out_data", out_data, held);
            check("bp_out_tag", 64'(out_tag), 64'd2);
            @(negedge clk);
        end
        check("bp_emit_hold", 64'(emit_cnt), 64'd1);
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_emit_cnt", 64'(emit_cnt), 64'd2);
        check("bp_tag", 64'(cb_reorder_tag), 64'd3);
        check("bp_out_valid_low", 64'(out_valid), 64'd0);

        // Ready status with nothing allocated is ignored.
        status[3] = 2'b11;
        repeat (4) begin
            @(negedge clk);
            check("empty_idle", 64'({mem_rd_en, out_valid, clr_valid}), 64'd0);
            check("empty_tag", 64'(cb_reorder_tag), 64'd3);
        end
        status[3] = 2'b00;

        // Fill to capacity, then overflow.
        alloc_burst(49);
        @(negedge clk);
        check("fill49_stall", 64'(alloc_stall), 64'd0);
        alloc_burst(1);
        @(negedge clk);
        check("fill50_stall", 64'(alloc_stall), 64'd1);
        check("fill50_overflow", 64'(overflow_err), 64'd0);
        tick();
        alloc_valid = 1'b1;
        tick();
        alloc_valid = 1'b0;
        @(negedge clk);
        check("ovf_err", 64'(overflow_err), 64'd1);
        check("ovf_stall", 64'(alloc_stall), 64'd1);

        // Reset while a packet sits in SEND.
        tick();
        out_ready = 1'b0;
        set_status(3, 2'b11);
        wait_out(10);
        tick();
        mon_en = 1'b0;
        rst    = 1'b0;
        #1;
        check("mrst_out_valid", 64'(out_valid), 64'd0);
        check("mrst_out_data", out_data, 64'd0);
        check("mrst_out_tag", 64'(out_tag), 64'd0);
        check("mrst_tag", 64'(cb_reorder_tag), 64'd0);
        check("mrst_rd", 64'({mem_rd_en, mem_rd_addr}), 64'd0);
        check("mrst_clr", 64'({clr_valid, clr_tag}), 64'd0);
        check("mrst_counts", {32'd0, emit_cnt, drop_cnt}, 64'd0);
        check("mrst_flags", 64'({overflow_err, alloc_stall}), 64'd0);
        exp_out.delete();
        exp_clr.delete();
        for (int i = 0; i < 64; i++) status[i] = 2'b00;
        wr_ptr = 0;
        @(negedge clk);
        tick();
        rst       = 1'b1;
        mon_en    = 1'b1;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_clr", 64'(clr_valid), 64'd0);
            check("post_rst_tag", 64'(cb_reorder_tag), 64'd0);
        end

        // 100 packets alternating pass/drop across two full wraps.
        for (int r = 0; r < 2; r++) begin
            alloc_burst(50);
            tick();
            for (int k = 0; k < N; k++) set_status(k, (k % 2 == 0) ? 2'b11 : 2'b01);
            wait_drain(400);
            @(negedge clk);
            check("wrap_tag", 64'(cb_reorder_tag), 64'd0);
        end
        check("bulk_emit_cnt", 64'(emit_cnt), 64'd50);
        check("bulk_drop_cnt", 64'(drop_cnt), 64'd50);
        check("bulk_stall", 64'(alloc_stall), 64'd0);
        check("bulk_overflow", 64'(overflow_err), 64'd0);
        alloc_burst(49);
        @(negedge clk);
        check("bulk_occ49_stall", 64'(alloc_stall), 64'd0);
        alloc_burst(1);
        @(negedge clk);
        check("bulk_occ50_stall", 64'(alloc_stall), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/packet_reorder_emitter.md
PACKET_REORDER_EMITTER -- requirements
Module: packet_reorder_emitter

Interface
REQ-001 SHALL have parameter TAG_WIDTH, default 6, width of reorder tags.
REQ-002 SHALL have parameter CIRCULAR_BUFFER_SIZE, default 50, number of slots; tags run 0..CIRCULAR_BUFFER_SIZE-1.
REQ-003 SHALL have parameter DATA_WIDTH, default 64, width of the packet descriptor word.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 alloc_valid  in  1  upstream wrote a new packet into the next slot.
REQ-007 alloc_stall  out  1  buffer full; upstream SHALL NOT allocate.
REQ-008 cb_reorder_tag  out  TAG_WIDTH  slot currently awaiting status; drives packet status table read address.
REQ-009 cb_rd_packet_status  in  2  bit0 = status ready, bit1 = pass(1)/drop(0), for cb_reorder_tag.
REQ-010 clr_valid / clr_tag  out  1 / TAG_WIDTH  one-cycle request to reset the table entry to pending.
REQ-011 mem_rd_en / mem_rd_addr  out  1 / TAG_WIDTH  slot storage read; data returns exactly 1 cycle later.
REQ-012 mem_rd_data  in  DATA_WIDTH  slot storage read data.
REQ-013 out_valid / out_ready / out_data / out_tag  out / in / out / out  1 / 1 / DATA_WIDTH / TAG_WIDTH  downstream valid-ready packet stream.
REQ-014 emit_cnt / drop_cnt  out  16 / 16  wrapping counts of emitted and dropped packets.
REQ-015 overflow_err  out  1  sticky: alloc_valid seen while full.

Function
REQ-016 SHALL implement FSM states WAIT, FETCH, SEND.
REQ-017 WAIT: if occupancy > 0 and status bit0 = 1 and bit1 = 1 -> FETCH; bit1 = 0 -> drop; otherwise stay.
REQ-018 Status with occupancy = 0 SHALL be ignored (stay WAIT, no pulses).
REQ-019 Drop: at the WAIT edge, SHALL register clr_valid = 1, clr_tag = old tag, advance tag, decrement occupancy, increment drop_cnt; stay WAIT.
REQ-020 FETCH: mem_rd_en = 1, mem_rd_addr = cb_reorder_tag for exactly one cycle; next state SEND, capturing mem_rd_data on the edge leaving the following cycle's read return.
REQ-021 SEND: out_valid = 1, out_data = captured word, out_tag = cb_reorder_tag; out_data/out_tag SHALL remain stable until out_valid && out_ready.
REQ-022 SEND handshake: SHALL pulse clr_valid for old tag next cycle, advance tag, decrement occupancy, increment emit_cnt, return to WAIT.
REQ-023 Minimum pass latency: status ready in WAIT at cycle N -> out_valid at cycle N+2 (FETCH at N+1); with out_ready held high, next tag in WAIT at N+3.
REQ-024 Tag advance: CIRCULAR_BUFFER_SIZE-1 wraps to 0; otherwise +1.
REQ-025 Occupancy counter 0..CIRCULAR_BUFFER_SIZE: +1 on accepted alloc, -1 on release; simultaneous alloc and release -> unchanged.
REQ-026 alloc_stall = (occupancy == CIRCULAR_BUFFER_SIZE), combinational from register.
REQ-027 alloc_valid while full SHALL be ignored and set overflow_err until reset.
REQ-028 Status table SHALL NOT be sampled in FETCH or SEND.
REQ-029 Counters SHALL wrap 0xFFFF -> 0x0000.

Reset
REQ-030 rst low SHALL immediately force: state WAIT, cb_reorder_tag 0, occupancy 0, all valid/enable outputs 0, out_data 0, out_tag 0, clr_tag 0, mem_rd_addr 0, counters 0, overflow_err 0, alloc_stall 0.
REQ-031 Reset asserted mid-SEND SHALL drop the in-flight packet with no clr pulse; operation resumes from tag 0 after release.

Verification
REQ-032 One alloc, status 2'b11 on tag 0, out_ready = 1 -> mem_rd_en at N+1 addr 0, out_valid at N+2 with out_tag 0, clr_valid tag 0 at N+3, emit_cnt = 1.
REQ-033 One alloc, status 2'b01 on tag 0 -> no out_valid, clr_valid tag 0 next cycle, drop_cnt = 1, cb_reorder_tag = 1.
REQ-034 out_ready low 5 cycles in SEND -> out_valid, out_data, out_tag constant all 5 cycles; single emit after ready rises.
REQ-035 50 allocs with no releases -> alloc_stall = 1; 51st alloc -> occupancy stays 50, overflow_err = 1.
REQ-036 100 packets alternating pass/drop, all status ready -> tag wraps 49 -> 0 twice, emit_cnt = 50, drop_cnt = 50, occupancy returns 0.
REQ-037 Status 2'b11 with occupancy 0 -> no FETCH, no pulses; rst low during SEND -> all outputs at reset values before next edge.
